// File: rtl/mem_access_stage.sv
// Memory-stage load/store unit: byte-lanes stores, runs a req/ready handshake
// with data memory, and aligns/extends load data into RDM for MEM/WB.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memReadM,
   input  logic        memWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] writeDataM,
   output logic        dmemReq,
   output logic        dmemWe,
   output logic [31:0] dmemAddr,
   output logic [31:0] dmemWData,
   output logic [3:0]  dmemBE,
   input  logic        dmemReady,
   input  logic [31:0] dmemRData,
   output logic [31:0] RDM,
   output logic        stallM,
   output logic        errM
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic             we_q, we_d;
   logic [2:0]       f3_q, f3_d;
   logic [31:0]      rdm_q, rdm_d;
   logic             err_q, err_d;

   logic        access, is_store, f3_ok, misalign, legal;
   logic [3:0]  be_st;
   logic [31:0] wd_st;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Legality of the access currently presented by EX/MEM; a load wins over a store.
   always_comb begin
      access   = memReadM | memWriteM;
      is_store = memWriteM & ~memReadM;
      f3_ok    = 1'b0;
      unique case (funct3M)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = memReadM;
         default:                f3_ok = 1'b0;
      endcase
      misalign = ((funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                 ((funct3M[1:0] == 2'b10) & (|ALUResultM[1:0]));
      legal    = f3_ok & ~misalign;
   end

   // Store byte enables and lane-replicated write data.
   always_comb begin
      be_st = 4'b1111;
      wd_st = writeDataM;
      unique case (funct3M[1:0])
         2'b00: begin
            be_st = 4'b0001 << ALUResultM[1:0];
            wd_st = {4{writeDataM[7:0]}};
         end
         2'b01: begin
            be_st = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wd_st = {2{writeDataM[15:0]}};
         end
         default: begin
            be_st = 4'b1111;
            wd_st = writeDataM;
         end
      endcase
   end

   // Load lane selection and extension, using the registered offset and funct3.
   always_comb begin
      unique case (addr_q[1:0])
         2'd0:    ld_byte = dmemRData[7:0];
         2'd1:    ld_byte = dmemRData[15:8];
         2'd2:    ld_byte = dmemRData[23:16];
         default: ld_byte = dmemRData[31:24];
      endcase
      ld_half = addr_q[1] ? dmemRData[31:16] : dmemRData[15:0];
      unique case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = dmemRData;
      endcase
   end

   // Next-state logic for the IDLE/BUSY/DONE handshake FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      we_d    = we_q;
      f3_d    = f3_q;
      rdm_d   = rdm_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (access) begin
               if (legal) begin
                  addr_d  = ALUResultM;
                  wdata_d = is_store ? wd_st : writeDataM;
                  be_d    = is_store ? be_st : 4'b1111;
                  we_d    = is_store;
                  f3_d    = funct3M;
                  state_d = BUSY;
               end else begin
                  rdm_d = '0;
                  err_d = 1'b1;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dmemReady) begin
               rdm_d   = we_q ? 32'd0 : ld_ext;
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // Last allowed BUSY cycle without ready: abort the access.
               rdm_d   = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         rdm_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         rdm_q   <= rdm_d;
         err_q   <= err_d;
      end
   end

   // Memory-side outputs are only asserted while the request is outstanding.
   always_comb begin
      dmemReq   = (state_q == BUSY);
      dmemWe    = dmemReq & we_q;
      dmemBE    = dmemReq ? be_q : 4'b0000;
      dmemAddr  = {addr_q[31:2], 2'b00};
      dmemWData = wdata_q;
      RDM       = rdm_q;
      errM      = err_q;
      stallM    = dmemReq | ((state_q == IDLE) & access & legal);
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// loads/stores compared every cycle against a behavioural model.
module tb_mem_access_stage;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        memReadM, memWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM, writeDataM;
   logic        dmemReq, dmemWe;
   logic [31:0] dmemAddr, dmemWData;
   logic [3:0]  dmemBE;
   logic        dmemReady;
   logic [31:0] dmemRData;
   logic [31:0] RDM;
   logic        stallM, errM;

   mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .memReadM   (memReadM),
      .memWriteM  (memWriteM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .writeDataM (writeDataM),
      .dmemReq    (dmemReq),
      .dmemWe     (dmemWe),
      .dmemAddr   (dmemAddr),
      .dmemWData  (dmemWData),
      .dmemBE     (dmemBE),
      .dmemReady  (dmemReady),
      .dmemRData  (dmemRData),
      .RDM        (RDM),
      .stallM     (stallM),
      .errM       (errM)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int stall_cnt = 0;

   // Per-cycle expectations produced by the model.
   bit          chk_en = 0;
   bit          e_stall = 0, e_req = 0, e_err = 0, e_we = 0;
   logic [31:0] e_rdm = 0, e_addr = 0, e_wd = 0;
   logic [3:0]  e_be = 0;
   logic [31:0] rdm_model = 0;
   bit          pend_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      int unsigned o = addr % 4;
      logic [31:0] v;
      case (f3)
         3'd0, 3'd4: begin
            v = (rdata >> (8 * o)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
         end
         3'd1, 3'd5: begin
            v = (rdata >> (16 * (o / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
         end
         default: v = rdata;
      endcase
      return v;
   endfunction

   function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                      input logic [31:0] addr);
      int unsigned bytes = 1 << (f3 % 4);
      bit ok;
      if (!(rd || wr)) return 1'b0;
      if (rd) ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      else    ok = (f3 <= 2);
      return ok && (addr % bytes == 0);
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned bytes = 1 << (f3 % 4);
      logic [31:0] t;
      t = ((32'd1 << bytes) - 32'd1) << (addr % 4);
      return t[3:0];
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
      case (f3 % 4)
         0:       return (wd & 32'hFF) * 32'h01010101;
         1:       return (wd & 32'hFFFF) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   // Single compare process: checks every cycle against the current expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stallM", {31'd0, stallM}, {31'd0, e_stall});
         chk("dmemReq", {31'd0, dmemReq}, {31'd0, e_req});
         chk("errM", {31'd0, errM}, {31'd0, e_err});
         chk("RDM", RDM, e_rdm);
         if (e_req) begin
            chk("dmemWe", {31'd0, dmemWe}, {31'd0, e_we});
            chk("dmemAddr", dmemAddr, e_addr);
            chk("dmemBE", {28'd0, dmemBE}, {28'd0, e_be});
            if (e_we) chk("dmemWData", dmemWData, e_wd);
         end
         if (stallM) stall_cnt++;
      end
   end

   task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int delay, input bit use_lit,
                          input logic [31:0] lit_rdm, input logic [3:0] lit_be,
                          input logic [31:0] lit_wd);
      bit legal   = model_legal(rd, wr, f3, addr);
      bit timeout = (delay >= int'(TIMEOUT));
      @(posedge clk); #1;
      memReadM = rd; memWriteM = wr; funct3M = f3; ALUResultM = addr; writeDataM = wd;
      dmemReady = 1'($urandom % 2); dmemRData = $urandom;
      stall_cnt = 0;
      e_stall = legal; e_req = 0; e_err = pend_err; e_rdm = rdm_model;
      pend_err = 0;
      if (legal) begin
         for (int i = 0; i < int'(TIMEOUT); i++) begin
            @(posedge clk); #1;
            dmemReady = (i == delay);
            dmemRData = dmemReady ? rdata : $urandom;
            e_stall = 1; e_req = 1; e_err = 0; e_rdm = rdm_model;
            e_we   = rd ? 1'b0 : wr;
            e_addr = addr & 32'hFFFFFFFC;
            e_be   = rd ? 4'hF : (use_lit ? lit_be : model_be(f3, addr));
            e_wd   = use_lit ? lit_wd : model_wd(f3, wd);
            if (i == delay) break;
         end
         if (timeout) rdm_model = 0;
         else if (rd) rdm_model = use_lit ? lit_rdm : model_load(f3, addr, rdata);
         else rdm_model = 0;
         @(posedge clk); #1;
         dmemReady = 1'($urandom % 2); dmemRData = $urandom;
         e_stall = 0; e_req = 0; e_err = timeout; e_rdm = rdm_model;
      end else if (rd || wr) begin
         rdm_model = 0;
         pend_err  = 1;
      end
      @(negedge clk); #1;
   endtask

   task automatic idle_cyc();
      run_txn(0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 0, 0, 32'd0, 4'd0, 32'd0);
   endtask

   initial begin
      rst = 0; memReadM = 0; memWriteM = 0; funct3M = 0; ALUResultM = 0; writeDataM = 0;
      dmemReady = 0; dmemRData = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", {31'd0, dmemReq}, 32'd0);
      chk("rst_we", {31'd0, dmemWe}, 32'd0);
      chk("rst_be", {28'd0, dmemBE}, 32'd0);
      chk("rst_rdm", RDM, 32'd0);
      chk("rst_err", {31'd0, errM}, 32'd0);
      @(posedge clk); #1;
      rst = 1;
      chk_en = 1;

      // LW, ready in first BUSY cycle: two stall cycles.
      run_txn(1, 0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 4'hF, 32'd0);
      chk("lw_stall_cycles", stall_cnt, 2);
      run_txn(1, 0, 3'd0, 32'h103, 32'd0, 32'h80123456, 0, 1, 32'hFFFFFF80, 4'hF, 32'd0);
      run_txn(1, 0, 3'd4, 32'h103, 32'd0, 32'h80123456, 1, 1, 32'h00000080, 4'hF, 32'd0);
      run_txn(1, 0, 3'd1, 32'h102, 32'd0, 32'h80123456, 0, 1, 32'hFFFF8012, 4'hF, 32'd0);

      // Asynchronous reset in the middle of a BUSY phase.
      chk_en = 0;
      @(posedge clk); #1;
      memReadM = 1; funct3M = 3'd2; ALUResultM = 32'h40; dmemReady = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_req", {31'd0, dmemReq}, 32'd1);
      rst = 0; #1;
      chk("midrst_req", {31'd0, dmemReq}, 32'd0);
      chk("midrst_rdm", RDM, 32'd0);
      chk("midrst_err", {31'd0, errM}, 32'd0);
      memReadM = 0;
      @(posedge clk); #1;
      rst = 1; rdm_model = 0; pend_err = 0;
      e_stall = 0; e_req = 0; e_err = 0; e_rdm = 0;
      chk_en = 1;
      run_txn(1, 0, 3'd2, 32'h200, 32'd0, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 4'hF, 32'd0);

      // Stores.
      run_txn(0, 1, 3'd0, 32'h21, 32'h000000AB, 32'd0, 0, 1, 32'd0, 4'b0010, 32'hABABABAB);
      run_txn(0, 1, 3'd1, 32'h22, 32'h1234CDEF, 32'd0, 2, 1, 32'd0, 4'b1100, 32'hCDEFCDEF);

      // Misaligned LW: no request, error pulse in the following cycle.
      run_txn(1, 0, 3'd2, 32'h102, 32'd0, 32'd0, 0, 0, 32'd0, 4'd0, 32'd0);
      chk("misalign_stall_cycles", stall_cnt, 0);
      idle_cyc();
      idle_cyc();

      // Slow memory, then a timeout.
      run_txn(1, 0, 3'd2, 32'h300, 32'd0, 32'h13572468, 4, 0, 32'd0, 4'd0, 32'd0);
      chk("delay_stall_cycles", stall_cnt, 6);
      run_txn(1, 0, 3'd2, 32'h304, 32'd0, 32'h11111111, 16, 0, 32'd0, 4'd0, 32'd0);
      chk("timeout_stall_cycles", stall_cnt, 17);
      run_txn(0, 1, 3'd2, 32'h308, 32'h55AA55AA, 32'd0, 20, 0, 32'd0, 4'd0, 32'd0);

      // Randomized mix.
      for (int n = 0; n < 300; n++) begin
         int unsigned kind = $urandom % 8;
         bit rd = (kind >= 1 && kind <= 4);
         bit wr = (kind >= 4);
         logic [2:0] f3;
         logic [31:0] addr;
         int dly;
         if ($urandom % 5 == 0) f3 = 3'($urandom % 8);
         else if (rd) f3 = 3'(($urandom % 2) ? ($urandom % 3) : 4 + ($urandom % 2));
         else f3 = 3'($urandom % 3);
         addr = $urandom;
         if ($urandom % 4 != 0) addr = addr & ~((32'd1 << (f3 % 4)) - 32'd1);
         dly = ($urandom % 10 == 0) ? 16 + int'($urandom % 4) : int'($urandom % 6);
         run_txn(rd, wr, f3, addr, $urandom, $urandom, dly, 0, 32'd0, 4'd0, 32'd0);
      end
      idle_cyc();
      idle_cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
